// File: rtl/nn_pkg.sv
`default_nettype none
//============================================================================
// Module      : nn_pkg
// Description : Shared types and constants for the network output stage:
//               result-sink state encoding, frame counter width and a
//               helper that sizes the class index for a given vector length.
// Revision    : 1.0 - initial release
//============================================================================
package nn_pkg;

    // Result sink states: gathering elements, or presenting a result
    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    localparam int FRAME_CNT_W = 16;

    // Bits needed to index M elements (at least one bit)
    function automatic int class_width(input int m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nn_max_update.sv
`default_nettype none
//============================================================================
// Module      : nn_max_update
// Description : Combinational running-maximum step. Decides whether the
//               incoming element replaces the current maximum (first
//               element of a vector, or strictly greater as signed) and
//               returns the resulting maximum and its index.
// Revision    : 1.0 - initial release
//============================================================================
module nn_max_update #(
    parameter int T  = 16,
    parameter int CW = 2
) (
    input  logic                 first,
    input  logic signed [T-1:0]  data_in,
    input  logic signed [T-1:0]  max_reg,
    input  logic        [CW-1:0] elem_cnt,
    input  logic        [CW-1:0] cur_idx,
    output logic signed [T-1:0]  next_max,
    output logic        [CW-1:0] next_idx
);

    // Strict compare keeps the earliest of equal maxima
    always_comb begin
        next_max = max_reg;
        next_idx = cur_idx;
        if (first || (data_in > max_reg)) begin
            next_max = data_in;
            next_idx = elem_cnt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/nn_argmax_sink.sv
`default_nettype none
//============================================================================
// Module      : nn_argmax_sink
// Description : Consumes an M-element signed result vector over a
//               valid/ready stream, tracks the running maximum and then
//               presents the index of the largest element (first occurrence
//               on ties) on an output valid/ready port. Counts delivered
//               results with a saturating frame counter.
//               Optional: define NN_ARGMAX_SCORE_EN to expose the maximum
//               value itself on score_out.
// Revision    : 1.0 - initial release
//============================================================================
module nn_argmax_sink
    import nn_pkg::*;
#(
    parameter int M  = 4,
    parameter int T  = 16,
    parameter int CW = class_width(M)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic signed [T-1:0]    data_in,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [CW-1:0]          class_out,
    output logic [FRAME_CNT_W-1:0] frame_cnt
`ifdef NN_ARGMAX_SCORE_EN
    ,
    output logic signed [T-1:0]    score_out
`endif
);

    localparam logic [CW-1:0]          LAST_IDX  = CW'(M - 1);
    localparam logic [FRAME_CNT_W-1:0] FRAME_MAX = {FRAME_CNT_W{1'b1}};

    state_t                   state_q, state_d;
    logic [CW-1:0]            elem_cnt_q, elem_cnt_d;
    logic signed [T-1:0]      max_q, max_d;
    logic [CW-1:0]            class_q, class_d;
    logic [FRAME_CNT_W-1:0]   frame_cnt_q, frame_cnt_d;

    logic                     accept;
    logic signed [T-1:0]      upd_max;
    logic [CW-1:0]            upd_idx;

    // Handshake flags are pure decodes of the state register
    assign s_ready   = (state_q == COLLECT);
    assign m_valid   = (state_q == HOLD);
    assign accept    = s_valid && s_ready;
    assign class_out = class_q;
    assign frame_cnt = frame_cnt_q;
`ifdef NN_ARGMAX_SCORE_EN
    assign score_out = max_q;
`endif

    nn_max_update #(
        .T  (T),
        .CW (CW)
    ) u_max_update (
        .first    (elem_cnt_q == '0),
        .data_in  (data_in),
        .max_reg  (max_q),
        .elem_cnt (elem_cnt_q),
        .cur_idx  (class_q),
        .next_max (upd_max),
        .next_idx (upd_idx)
    );

    // Next-state: collect M elements, then hold the result until taken
    always_comb begin
        state_d     = state_q;
        elem_cnt_d  = elem_cnt_q;
        max_d       = max_q;
        class_d     = class_q;
        frame_cnt_d = frame_cnt_q;
        unique case (state_q)
            COLLECT: begin
                if (accept) begin
                    max_d   = upd_max;
                    class_d = upd_idx;
                    if (elem_cnt_q == LAST_IDX) begin
                        elem_cnt_d = '0;
                        state_d    = HOLD;
                    end else begin
                        elem_cnt_d = elem_cnt_q + CW'(1);
                    end
                end
            end
            HOLD: begin
                if (m_ready) begin
                    state_d = COLLECT;
                    if (frame_cnt_q != FRAME_MAX) begin
                        frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
                    end
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    // State and datapath registers; reset discards any partial vector
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= COLLECT;
            elem_cnt_q  <= '0;
            max_q       <= '0;
            class_q     <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            elem_cnt_q  <= elem_cnt_d;
            max_q       <= max_d;
            class_q     <= class_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nn_argmax_sink.sv
`default_nettype none
//============================================================================
// Module      : tb_nn_argmax_sink
// Description : Self-checking bench for nn_argmax_sink (M=4, T=16).
//               Table vectors plus hand-written backpressure, reset and
//               random-gap sequences; results checked through a queue.
// Revision    : 1.0 - initial release
//============================================================================
module tb_nn_argmax_sink;
    import nn_pkg::*;

    localparam int M = 4;
    localparam int T = 16;

    typedef struct {
        logic [T-1:0] e [M];
        logic [1:0]   cls;
        logic [T-1:0] score;
    } vec_t;

    typedef struct {
        logic [1:0]   cls;
        logic [T-1:0] score;
    } res_t;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   s_valid = 1'b0;
    logic                   s_ready;
    logic [T-1:0]           data_in = '0;
    logic                   m_valid;
    logic                   m_ready = 1'b1;
    logic [1:0]             class_out;
    logic [FRAME_CNT_W-1:0] frame_cnt;
`ifdef NN_ARGMAX_SCORE_EN
    logic [T-1:0]           score_out;
`endif

    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_frames = 0;
    res_t exp_q[$];
    vec_t tbl [6];

    always #5 clk = ~clk;

    nn_argmax_sink #(.M(M), .T(T)) dut (
        .clk       (clk),
        .reset     (reset),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .data_in   (data_in),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .class_out (class_out),
        .frame_cnt (frame_cnt)
`ifdef NN_ARGMAX_SCORE_EN
        ,
        .score_out (score_out)
`endif
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Scoreboard: every delivered result must match the oldest expectation
    always @(negedge clk) begin
        if (!reset && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 32'd1, 32'd0);
            end else begin
                res_t r;
                r = exp_q.pop_front();
                chk("class_out", 32'(class_out), 32'(r.cls));
`ifdef NN_ARGMAX_SCORE_EN
                chk("score_out", 32'(score_out), 32'(r.score));
`endif
                chk("frame_cnt_before", 32'(frame_cnt), 32'(exp_frames));
                exp_frames++;
            end
        end
    end

    task automatic send_elem(input logic [T-1:0] d);
        bit ok;
        ok = 1'b0;
        s_valid = 1'b1;
        data_in = d;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (s_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
                break;
            end
        end
        s_valid = 1'b0;
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_vec(input logic [T-1:0] v [M], input logic [1:0] cls,
                            input logic [T-1:0] score, input int max_gap);
        res_t r;
        for (int i = 0; i < M; i++) begin
            int gap;
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            for (int g = 0; g < gap; g++) begin
                @(posedge clk);
                #1;
            end
            send_elem(v[i]);
        end
        // One cycle after the last accept the result must be up
        chk("latency_m_valid", 32'(m_valid), 32'd1);
        chk("hold_s_ready", 32'(s_ready), 32'd0);
        r.cls = cls;
        r.score = score;
        exp_q.push_back(r);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("reset_m_valid", 32'(m_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        exp_q.delete();
        exp_frames = 0;
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [T-1:0] v [M];
        logic [1:0]   ref_cls;
        logic [T-1:0] ref_max;

        tbl[0].e = '{16'd5, 16'hFFFD, 16'd12, 16'd7};       tbl[0].cls = 2'd2; tbl[0].score = 16'd12;
        tbl[1].e = '{16'd9, 16'd9, 16'd1, 16'd0};           tbl[1].cls = 2'd0; tbl[1].score = 16'd9;
        tbl[2].e = '{16'd0, 16'd3, 16'd3, 16'd3};           tbl[2].cls = 2'd1; tbl[2].score = 16'd3;
        tbl[3].e = '{16'hFFFF, 16'hFFFB, 16'hFFFE, 16'hFFF8}; tbl[3].cls = 2'd0; tbl[3].score = 16'hFFFF;
        tbl[4].e = '{16'h8000, 16'hFFF9, 16'h7FFF, 16'd0};  tbl[4].cls = 2'd2; tbl[4].score = 16'h7FFF;
        tbl[5].e = '{16'hFFF0, 16'hFFF0, 16'hFFF0, 16'hFFF0}; tbl[5].cls = 2'd0; tbl[5].score = 16'hFFF0;

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_s_ready", 32'(s_ready), 32'd1);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_class", 32'(class_out), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
`ifdef NN_ARGMAX_SCORE_EN
        chk("rst_score", 32'(score_out), 32'd0);
`endif
        @(posedge clk);
        #1;

        // First table vector alone, then the rest back-to-back
        send_vec(tbl[0].e, tbl[0].cls, tbl[0].score, 0);
        wait_drain();
        chk("frame_cnt_single", 32'(frame_cnt), 32'd1);
        for (int i = 1; i < 6; i++) send_vec(tbl[i].e, tbl[i].cls, tbl[i].score, 0);
        wait_drain();
        chk("frame_cnt_table", 32'(frame_cnt), 32'd6);

        // Backpressure: result held, nothing accepted while s_valid stays high
        m_ready = 1'b0;
        v = '{16'd1, 16'd2, 16'd3, 16'd4};
        send_vec(v, 2'd3, 16'd4, 0);
        s_valid = 1'b1;
        data_in = 16'h7FFF;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_s_ready", 32'(s_ready), 32'd0);
            chk("bp_m_valid", 32'(m_valid), 32'd1);
            chk("bp_class", 32'(class_out), 32'd3);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_s_ready", 32'(s_ready), 32'd1);
        chk("bp_release_m_valid", 32'(m_valid), 32'd0);
        chk("bp_class_kept", 32'(class_out), 32'd3);
        // Vector after backpressure proves element alignment survived
        v = '{16'd7, 16'd1, 16'd2, 16'd3};
        send_vec(v, 2'd0, 16'd7, 0);
        wait_drain();
        chk("frame_cnt_bp", 32'(frame_cnt), 32'd8);

        // Reset mid-vector discards the partial vector
        send_elem(16'd100);
        send_elem(16'd200);
        do_reset();
        v = '{16'd1, 16'd4, 16'd2, 16'd3};
        send_vec(v, 2'd1, 16'd4, 0);
        wait_drain();
        chk("frame_cnt_after_reset", 32'(frame_cnt), 32'd1);

        // Random vectors with random s_valid gaps against a reference argmax
        do_reset();
        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < M; i++) v[i] = T'($urandom);
            if (n == 0) v[3] = v[1];
            ref_cls = 2'd0;
            ref_max = v[0];
            for (int i = 1; i < M; i++) begin
                if ($signed(v[i]) > $signed(ref_max)) begin
                    ref_max = v[i];
                    ref_cls = 2'(i);
                end
            end
            send_vec(v, ref_cls, ref_max, 3);
        end
        wait_drain();
        chk("frame_cnt_random", 32'(frame_cnt), 32'd3);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nn_argmax_sink.md
# nn_argmax_sink

Stream consumer for the output side of a fully connected layer. It accepts the M-element result vector from the layer's valid/ready output port and tracks a running maximum. When the vector is complete it presents the index of the largest element (the classification result) on its own valid/ready port. It sits directly after the last layer of the network, as the receiving end of that layer's output handshake.

## Interface
- M, 4: elements per result vector; must be ≥ 2.
- T, 16: element width in bits, signed two's complement.
- CW, $clog2(M): class index width.
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high.
- s_valid  input  1  upstream element valid; connects to the layer's m_valid.
- s_ready  output  1  element accepted when s_valid && s_ready; connects to the layer's m_ready.
- data_in  input  T  signed element; connects to the layer's data_out.
- m_valid  output  1  class result valid.
- m_ready  input  1  downstream accepts the result.
- class_out  output  CW  index of the maximum element, 0-based in arrival order.
- frame_cnt  output  16  number of results delivered since reset; saturates at 16'hFFFF.
- score_out  output  T  maximum element value; present only with NN_ARGMAX_SCORE_EN.

## Operation
- Reset values:
  - state=COLLECT, s_ready=1, m_valid=0, class_out=0, frame_cnt=0, score_out=0.
  - Internal elem_cnt=0, max_reg=0.
- State COLLECT:
  - s_ready=1, m_valid=0.
  - On each accept, elem_cnt increments.
  - If elem_cnt==0, or data_in > max_reg as a signed compare, then max_reg<=data_in and class_out<=elem_cnt.
- Ties: the strict > means the first occurrence wins; later equal values never replace it.
- Last element: on the accept with elem_cnt==M-1:
  - the compare/update above still applies;
  - elem_cnt wraps to 0;
  - state moves to HOLD.
- State HOLD:
  - s_ready=0, m_valid=1.
  - class_out and score_out are held stable and s_valid is ignored.
  - On m_valid && m_ready: state moves to COLLECT and frame_cnt increments unless it equals 16'hFFFF.
- class_out and score_out keep their last value after the handshake, until the first accept of the next vector overwrites them.
- Input data is not registered beyond max_reg; there is no input FIFO.
- All compares are full T-bit signed. There is no width growth.

## Timing
- Result latency: m_valid rises the cycle after the M-th accept.
- Minimum period per vector is M+1 cycles: M accepts plus 1 output cycle when m_ready is held high.
- In HOLD, s_ready drops in the same cycle that m_valid rises. s_ready returns to 1 the cycle after the output handshake.
- The block never accepts an element and delivers a result in the same cycle.
- Backpressure: m_ready low holds HOLD indefinitely, with no loss and no change to outputs.
- s_valid gaps: elem_cnt and max_reg hold. Gaps are unlimited in length.
- Reset mid-vector discards the partial vector. The first accept after reset is element 0 of a new vector.
- m_valid never depends combinationally on m_ready. s_ready is a decode of the state register only.

## Configuration
- NN_ARGMAX_SCORE_EN defined:
  - score_out port exists and equals max_reg;
  - it is updated with the same timing as class_out.
- NN_ARGMAX_SCORE_EN undefined:
  - score_out port is absent;
  - max_reg remains internal;
  - all other behaviour is identical.

## Structure
- Shared package nn_pkg holds:
  - the state enum typedef {COLLECT, HOLD};
  - the FRAME_CNT_W=16 constant;
  - a function returning the class width for M.
- One sub-module, nn_max_update: a combinational signed compare/select.
  - Inputs: first flag, data_in, max_reg, elem_cnt.
  - Outputs: next max and next index.
  - It is instantiated once.
- The top level holds the FSM, the counters, the output registers and the handshake.

## Test plan
- Single vector: feed {5,-3,12,7} back-to-back with m_ready=1. Expect class_out=2 one cycle after the 4th accept, score_out=12 (macro on), frame_cnt=1.
- Ties: feed {9,9,1,0}, then {0,3,3,3}. Expect class_out=0, then 1.
- Signed compare: feed {-1,-5,-2,-8}. Expect class_out=0, score_out=-1. Feed {16'h8000,-7,16'h7FFF,0}. Expect class_out=2.
- Backpressure: hold m_ready=0 for 10 cycles after m_valid and keep s_valid=1. Expect s_ready=0 throughout, outputs stable and no element accepted. Then raise m_ready: s_ready=1 the next cycle.
- Reset mid-vector: accept {100,200}, pulse reset, then feed {1,4,2,3}. Expect class_out=1, frame_cnt=1 after the handshake, m_valid=0 during reset.
- Throughput and gaps: 3 random vectors with random s_valid gaps. Expect class_out to match a reference argmax with first-wins ties, and frame_cnt=3.
